// File: rtl/wb_stage_pkg.sv
// Shared MiniMIPS32 defines used by the write-back stage: bus widths,
// load aluop codes and the load-data hold FSM state type.
package wb_stage_pkg;

    localparam int REG_ADDR_BUS = 5;
    localparam int REG_BUS      = 32;
    localparam int ALUOP_BUS    = 8;

    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    // Load kinds as carried on aluop through EX/MEM
    localparam logic [ALUOP_BUS-1:0] LB  = 8'h90;
    localparam logic [ALUOP_BUS-1:0] LBU = 8'h91;
    localparam logic [ALUOP_BUS-1:0] LH  = 8'h92;
    localparam logic [ALUOP_BUS-1:0] LHU = 8'h93;
    localparam logic [ALUOP_BUS-1:0] LW  = 8'h94;

    // LIVE: load data comes straight from the RAM; HELD: from the stall latch
    typedef enum logic {
        LD_LIVE = 1'b0,
        LD_HELD = 1'b1
    } ld_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// wb_load_align: picks the byte/half/word selected by the byte-lane read
// enables and sign/zero-extends it. Lane 0 is bits 7:0. Any enable pattern
// that does not fit the load kind yields zero.
module wb_load_align
    import wb_stage_pkg::*;
#(
    parameter int DW  = REG_BUS,
    parameter int OPW = ALUOP_BUS
) (
    input  logic [OPW-1:0] aluop,
    input  logic [3:0]     dre,
    input  logic [DW-1:0]  data,
    output logic [DW-1:0]  aligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        hit;

    // Lane select then extension; illegal lane patterns fall through to zero
    always_comb begin
        aligned = ZERO_WORD;
        byte_v  = 8'h00;
        half_v  = 16'h0000;
        hit     = 1'b1;
        case (aluop)
            LB, LBU: begin
                case (dre)
                    4'b0001: byte_v = data[7:0];
                    4'b0010: byte_v = data[15:8];
                    4'b0100: byte_v = data[23:16];
                    4'b1000: byte_v = data[31:24];
                    default: hit = 1'b0;
                endcase
                if (hit)
                    aligned = (aluop == LB) ? {{(DW-8){byte_v[7]}}, byte_v}
                                            : {{(DW-8){1'b0}}, byte_v};
            end
            LH, LHU: begin
                case (dre)
                    4'b0011: half_v = data[15:0];
                    4'b1100: half_v = data[31:16];
                    default: hit = 1'b0;
                endcase
                if (hit)
                    aligned = (aluop == LH) ? {{(DW-16){half_v[15]}}, half_v}
                                            : {{(DW-16){1'b0}}, half_v};
            end
            LW: begin
                if (dre == 4'b1111)
                    aligned = data;
            end
            default: aligned = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back mux for MiniMIPS32.
// Drives the regfile write port. Load data from the synchronous data RAM is
// latched on the first stalled cycle so the write value stays stable while
// WB is held.
// Optional macro WB_TRACE_EN adds the PC pipeline register and debug trace
// ports; without it those ports and the PC register are absent.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int AW  = REG_ADDR_BUS,
    parameter int DW  = REG_BUS,
    parameter int OPW = ALUOP_BUS
) (
    input  logic           cpu_clk_50M,
    input  logic           cpu_rst,
    input  logic [AW-1:0]  mem_wa,
    input  logic           mem_wreg,
    input  logic [DW-1:0]  mem_wd,
    input  logic           mem_mreg,
    input  logic [OPW-1:0] mem_aluop,
    input  logic [3:0]     mem_dre,
    input  logic           stall_wb,
    input  logic           flush,
    input  logic [DW-1:0]  dm_rdata,
`ifdef WB_TRACE_EN
    input  logic [31:0]    mem_pc,
    output logic [31:0]    debug_wb_pc,
    output logic [3:0]     debug_wb_rf_wen,
    output logic [AW-1:0]  debug_wb_rf_wnum,
    output logic [DW-1:0]  debug_wb_rf_wdata,
`endif
    output logic [AW-1:0]  wb_wa,
    output logic [DW-1:0]  wb_wd,
    output logic           wb_we,
    output logic           wb_valid
);

    logic           valid_q;
    logic [AW-1:0]  wa_q;
    logic [DW-1:0]  wd_q;
    logic           wreg_q;
    logic           mreg_q;
    logic [OPW-1:0] aluop_q;
    logic [3:0]     dre_q;
    logic [DW-1:0]  ld_hold;
    ld_state_e      state_q, state_d;
    logic           hold_en;
    logic [DW-1:0]  ld_src;
    logic [DW-1:0]  ld_aligned;

    // MEM/WB register: reset > flush > stall > capture
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst || flush) begin
            valid_q <= 1'b0;
            wa_q    <= '0;
            wd_q    <= ZERO_WORD;
            wreg_q  <= 1'b0;
            mreg_q  <= 1'b0;
            aluop_q <= '0;
            dre_q   <= 4'b0000;
        end else if (!stall_wb) begin
            valid_q <= 1'b1;
            wa_q    <= mem_wa;
            wd_q    <= mem_wd;
            wreg_q  <= mem_wreg;
            mreg_q  <= mem_mreg;
            aluop_q <= mem_aluop;
            dre_q   <= mem_dre;
        end
    end

    // Hold FSM state and the load-data latch (sampled only on LIVE->HELD)
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q <= LD_LIVE;
            ld_hold <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            if (hold_en)
                ld_hold <= dm_rdata;
        end
    end

    // Next state: enter HELD on the first stalled cycle of a live load; a
    // flush wins over the stall, so a flushed load never gets latched
    always_comb begin
        state_d = state_q;
        hold_en = 1'b0;
        case (state_q)
            LD_LIVE: begin
                if (stall_wb && !flush && valid_q && mreg_q) begin
                    state_d = LD_HELD;
                    hold_en = 1'b1;
                end
            end
            LD_HELD: begin
                if (!stall_wb || flush)
                    state_d = LD_LIVE;
            end
            default: state_d = LD_LIVE;
        endcase
    end

    assign ld_src = (state_q == LD_HELD) ? ld_hold : dm_rdata;

    wb_load_align #(.DW(DW), .OPW(OPW)) u_align (
        .aluop   (aluop_q),
        .dre     (dre_q),
        .data    (ld_src),
        .aligned (ld_aligned)
    );

    // $0 writes are dropped here; a stalled instruction keeps rewriting
    // the same value, which is harmless
    assign wb_wa    = wa_q;
    assign wb_wd    = mreg_q ? ld_aligned : wd_q;
    assign wb_we    = valid_q & wreg_q & (wa_q != '0);
    assign wb_valid = valid_q;

`ifdef WB_TRACE_EN
    logic [31:0] pc_q;

    // PC follows the same reset/flush/stall rules as the other fields
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst || flush)
            pc_q <= 32'h0;
        else if (!stall_wb)
            pc_q <= mem_pc;
    end

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = {4{wb_we}};
    assign debug_wb_rf_wnum  = wb_wa;
    assign debug_wb_rf_wdata = wb_wd;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: reset, ALU write-back, load
// alignment table, stall hold of load data, flush, $0 suppression and reset
// during a stall.
module tb_wb_stage;

    localparam logic [7:0] OP_LB  = 8'h90;
    localparam logic [7:0] OP_LBU = 8'h91;
    localparam logic [7:0] OP_LH  = 8'h92;
    localparam logic [7:0] OP_LHU = 8'h93;
    localparam logic [7:0] OP_LW  = 8'h94;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst     = 1'b1;
    logic [4:0]  mem_wa      = '0;
    logic        mem_wreg    = 1'b0;
    logic [31:0] mem_wd      = '0;
    logic        mem_mreg    = 1'b0;
    logic [7:0]  mem_aluop   = '0;
    logic [3:0]  mem_dre     = '0;
    logic        stall_wb    = 1'b0;
    logic        flush       = 1'b0;
    logic [31:0] dm_rdata    = '0;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        wb_we;
    logic        wb_valid;
`ifdef WB_TRACE_EN
    logic [31:0] mem_pc = '0;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    int checks   = 0;
    int failures = 0;

    wb_stage dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .mem_wa      (mem_wa),
        .mem_wreg    (mem_wreg),
        .mem_wd      (mem_wd),
        .mem_mreg    (mem_mreg),
        .mem_aluop   (mem_aluop),
        .mem_dre     (mem_dre),
        .stall_wb    (stall_wb),
        .flush       (flush),
        .dm_rdata    (dm_rdata),
`ifdef WB_TRACE_EN
        .mem_pc            (mem_pc),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
`endif
        .wb_wa       (wb_wa),
        .wb_wd       (wb_wd),
        .wb_we       (wb_we),
        .wb_valid    (wb_valid)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic set_mem(input logic [4:0] wa, input logic wreg, input logic [31:0] wd,
                           input logic mreg, input logic [7:0] op, input logic [3:0] dre);
        mem_wa    = wa;
        mem_wreg  = wreg;
        mem_wd    = wd;
        mem_mreg  = mreg;
        mem_aluop = op;
        mem_dre   = dre;
    endtask

    // Load alignment vectors: aluop, dre, RAM word, expected write data
    logic [7:0]  t_op  [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LB, OP_LH, OP_LBU};
    logic [3:0]  t_dre [8] = '{4'b0100, 4'b0100, 4'b1100, 4'b0011, 4'b1111, 4'b1000, 4'b0110, 4'b0001};
    logic [31:0] t_rd  [8] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_1234, 32'h1234_F00F,
                               32'hDEAD_BEEF, 32'h7F00_0000, 32'hFFFF_FFFF, 32'h0000_00C3};
    logic [31:0] t_exp [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F00F,
                               32'hDEAD_BEEF, 32'h0000_007F, 32'h0000_0000, 32'h0000_00C3};

    initial begin
        // Reset
        step();
        step();
        chk("rst_wa", {27'b0, wb_wa}, 32'h0);
        chk("rst_wd", wb_wd, 32'h0);
        chk("rst_we", {31'b0, wb_we}, 32'h0);
        chk("rst_valid", {31'b0, wb_valid}, 32'h0);
        cpu_rst = 1'b0;

        // ALU result write-back
        set_mem(5'd5, 1'b1, 32'h1234_5678, 1'b0, 8'h00, 4'b0000);
        step();
        chk("alu_wa", {27'b0, wb_wa}, 32'd5);
        chk("alu_wd", wb_wd, 32'h1234_5678);
        chk("alu_we", {31'b0, wb_we}, 32'h1);
        chk("alu_valid", {31'b0, wb_valid}, 32'h1);

        // Load alignment table
        for (int i = 0; i < 8; i++) begin
            set_mem(5'd3, 1'b1, 32'h1000_0000, 1'b1, t_op[i], t_dre[i]);
            step();
            set_mem(5'd0, 1'b0, 32'h0, 1'b0, 8'h00, 4'b0000);
            dm_rdata = t_rd[i];
            #1;
            chk($sformatf("ld%0d_wd", i), wb_wd, t_exp[i]);
            chk($sformatf("ld%0d_we", i), {31'b0, wb_we}, 32'h1);
        end

        // Stalled load keeps first-cycle RAM data; MEM input must not be taken
        set_mem(5'd7, 1'b1, 32'h0000_0100, 1'b1, OP_LW, 4'b1111);
        step();
        set_mem(5'd9, 1'b1, 32'h0000_0055, 1'b0, 8'h00, 4'b0000);
        dm_rdata = 32'hAAAA_5555;
        stall_wb = 1'b1;
        #1;
        chk("stl_pre_wd", wb_wd, 32'hAAAA_5555);
        for (int i = 0; i < 3; i++) begin
            step();
            dm_rdata = 32'h0000_0000;
            #1;
            chk($sformatf("stl%0d_wd", i), wb_wd, 32'hAAAA_5555);
            chk($sformatf("stl%0d_we", i), {31'b0, wb_we}, 32'h1);
            chk($sformatf("stl%0d_wa", i), {27'b0, wb_wa}, 32'd7);
        end
        stall_wb = 1'b0;
        step();
        chk("post_stl_wa", {27'b0, wb_wa}, 32'd9);
        chk("post_stl_wd", wb_wd, 32'h0000_0055);

        // Stalled ALU op holds its fields
        set_mem(5'd8, 1'b1, 32'h0000_ABCD, 1'b0, 8'h00, 4'b0000);
        step();
        set_mem(5'd9, 1'b1, 32'h0000_0001, 1'b0, 8'h00, 4'b0000);
        stall_wb = 1'b1;
        step();
        chk("alu_stl_wd", wb_wd, 32'h0000_ABCD);
        chk("alu_stl_wa", {27'b0, wb_wa}, 32'd8);
        stall_wb = 1'b0;

        // Flush while stalled in HELD
        set_mem(5'd4, 1'b1, 32'h0, 1'b1, OP_LW, 4'b1111);
        step();
        set_mem(5'd0, 1'b0, 32'h0, 1'b0, 8'h00, 4'b0000);
        dm_rdata = 32'h1111_2222;
        stall_wb = 1'b1;
        step();
        dm_rdata = 32'h0;
        flush = 1'b1;
        step();
        chk("fl_valid", {31'b0, wb_valid}, 32'h0);
        chk("fl_we", {31'b0, wb_we}, 32'h0);
        flush = 1'b0;
        stall_wb = 1'b0;
        set_mem(5'd6, 1'b1, 32'h0, 1'b1, OP_LW, 4'b1111);
        step();
        set_mem(5'd0, 1'b0, 32'h0, 1'b0, 8'h00, 4'b0000);
        dm_rdata = 32'h3333_4444;
        #1;
        chk("fl_live_wd", wb_wd, 32'h3333_4444);
        chk("fl_live_valid", {31'b0, wb_valid}, 32'h1);

        // Plain flush kills the incoming instruction
        set_mem(5'd5, 1'b1, 32'h0000_0077, 1'b0, 8'h00, 4'b0000);
        flush = 1'b1;
        step();
        chk("fl2_valid", {31'b0, wb_valid}, 32'h0);
        chk("fl2_we", {31'b0, wb_we}, 32'h0);
        flush = 1'b0;

        // Writes to $0 are suppressed
        set_mem(5'd0, 1'b1, 32'h0000_0099, 1'b0, 8'h00, 4'b0000);
        step();
        chk("r0_we", {31'b0, wb_we}, 32'h0);
        chk("r0_valid", {31'b0, wb_valid}, 32'h1);
        chk("r0_wd", wb_wd, 32'h0000_0099);

        // Reset in the middle of a stalled load
        set_mem(5'd2, 1'b1, 32'h0, 1'b1, OP_LW, 4'b1111);
        step();
        set_mem(5'd0, 1'b0, 32'h0, 1'b0, 8'h00, 4'b0000);
        dm_rdata = 32'hCAFE_F00D;
        stall_wb = 1'b1;
        step();
        dm_rdata = 32'h0;
        cpu_rst = 1'b1;
        step();
        chk("mrst_wa", {27'b0, wb_wa}, 32'h0);
        chk("mrst_wd", wb_wd, 32'h0);
        chk("mrst_we", {31'b0, wb_we}, 32'h0);
        chk("mrst_valid", {31'b0, wb_valid}, 32'h0);
        cpu_rst = 1'b0;
        stall_wb = 1'b0;
        set_mem(5'd2, 1'b1, 32'h0, 1'b1, OP_LW, 4'b1111);
        step();
        set_mem(5'd0, 1'b0, 32'h0, 1'b0, 8'h00, 4'b0000);
        dm_rdata = 32'h0BAD_C0DE;
        #1;
        chk("mrst_live_wd", wb_wd, 32'h0BAD_C0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
